// File: rtl/ex_mem_pkg.sv
// Shared encodings and sizing helpers for the EX->MEM pipeline register.
package ex_mem_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int WW_W_DEF   = 8;
    localparam int RD_W_DEF   = 5;
    localparam int WB_SEL_W   = 2;

    typedef enum logic [WB_SEL_W-1:0] {
        WB_ALU = 2'd0,
        WB_MEM = 2'd1,
        WB_PC4 = 2'd2
    } wb_sel_e;

    // Packed layout: {is_write_dmem, reg_write, rd, wb_select, write_width, dmem_write_data, alu_res}
    function automatic int payload_w(input int data_w, input int ww_w, input int rd_w);
        return 2 + rd_w + WB_SEL_W + ww_w + 2 * data_w;
    endfunction

endpackage

// File: rtl/ex_mem_skid_pipe_skid.sv
// Generic two-slot skid buffer: main slot drives the output, skid slot absorbs
// one overflow entry so in_ready comes straight from a flop.
module pipe_skid
    import ex_mem_pkg::*;
#(
    parameter int PAYLOAD_W = 8
) (
    input  logic                 sys_clk,
    input  logic                 sys_rst,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [PAYLOAD_W-1:0] in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [PAYLOAD_W-1:0] out_data
);

    logic                 m_valid_q, m_valid_d;
    logic [PAYLOAD_W-1:0] m_data_q,  m_data_d;
    logic                 s_valid_q, s_valid_d;
    logic [PAYLOAD_W-1:0] s_data_q,  s_data_d;

    logic accept;
    logic drain;

    assign in_ready  = !s_valid_q;
    assign out_valid = m_valid_q;
    assign out_data  = m_data_q;

    assign accept = in_valid && in_ready;
    assign drain  = m_valid_q && out_ready;

    always_comb begin
        // NOTE: every _d starts from its _q so no path can infer a latch.
        m_valid_d = m_valid_q;
        m_data_d  = m_data_q;
        s_valid_d = s_valid_q;
        s_data_d  = s_data_q;

        if (flush) begin
            m_valid_d = 1'b0;
            s_valid_d = 1'b0;
        end else if (!m_valid_q || drain) begin
            // Main slot is free this edge: the older skid entry goes first.
            if (s_valid_q) begin
                m_valid_d = 1'b1;
                m_data_d  = s_data_q;
                s_valid_d = 1'b0;
            end else begin
                m_valid_d = accept;
                if (accept) m_data_d = in_data;
            end
        end else if (accept) begin
            s_valid_d = 1'b1;
            s_data_d  = in_data;
        end
    end

    // NOTE: payload registers are reset too, so the held fields read 0 after reset.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            m_valid_q <= 1'b0;
            m_data_q  <= '0;
            s_valid_q <= 1'b0;
            s_data_q  <= '0;
        end else begin
            // NOTE: non-blocking so every flop samples the pre-edge values.
            m_valid_q <= m_valid_d;
            m_data_q  <= m_data_d;
            s_valid_q <= s_valid_d;
            s_data_q  <= s_data_d;
        end
    end

endmodule

// File: rtl/ex_mem_skid.sv
// EX->MEM pipeline register with valid/ready skid buffering and flush.
// Define EX_MEM_FWD_EN to generate the ALU-result forwarding taps.
module ex_mem_skid
    import ex_mem_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int WW_W   = WW_W_DEF,
    parameter int RD_W   = RD_W_DEF
) (
    input  logic                sys_clk,
    input  logic                sys_rst,
    input  logic                flush,
    input  logic                ex_valid,
    output logic                ex_ready,
    input  logic                ex_is_write_dmem,
    input  logic                ex_reg_write,
    input  logic [RD_W-1:0]     ex_rd,
    input  logic [WB_SEL_W-1:0] ex_wb_select,
    input  logic [WW_W-1:0]     ex_write_width,
    input  logic [DATA_W-1:0]   ex_dmem_write_data,
    input  logic [DATA_W-1:0]   ex_alu_res,
    output logic                mem_valid,
    input  logic                mem_ready,
    output logic                mem_is_write_dmem,
    output logic                mem_reg_write,
    output logic [RD_W-1:0]     mem_rd,
    output logic [WB_SEL_W-1:0] mem_wb_select,
    output logic [WW_W-1:0]     mem_write_width,
    output logic [DATA_W-1:0]   mem_dmem_write_data,
    output logic [DATA_W-1:0]   mem_alu_res,
    output logic                fwd_valid,
    output logic [RD_W-1:0]     fwd_rd,
    output logic [DATA_W-1:0]   fwd_data
);

    localparam int PW = payload_w(DATA_W, WW_W, RD_W);

    logic [PW-1:0] ex_payload;
    logic [PW-1:0] mem_payload;
    logic          m_is_write_dmem;
    logic          m_reg_write;

    assign ex_payload = {ex_is_write_dmem, ex_reg_write, ex_rd, ex_wb_select,
                         ex_write_width, ex_dmem_write_data, ex_alu_res};

    pipe_skid #(
        .PAYLOAD_W (PW)
    ) u_skid (
        .sys_clk   (sys_clk),
        .sys_rst   (sys_rst),
        .flush     (flush),
        .in_valid  (ex_valid),
        .in_ready  (ex_ready),
        .in_data   (ex_payload),
        .out_valid (mem_valid),
        .out_ready (mem_ready),
        .out_data  (mem_payload)
    );

    assign {m_is_write_dmem, m_reg_write, mem_rd, mem_wb_select,
            mem_write_width, mem_dmem_write_data, mem_alu_res} = mem_payload;

    // Stale payload may linger in an empty slot; the strobes must never fire from it.
    assign mem_is_write_dmem = mem_valid && m_is_write_dmem;
    assign mem_reg_write     = mem_valid && m_reg_write;

`ifdef EX_MEM_FWD_EN
    assign fwd_valid = mem_valid && m_reg_write && (mem_rd != '0) &&
                       (mem_wb_select != WB_MEM);
    assign fwd_rd    = mem_rd;
    assign fwd_data  = mem_alu_res;
`else
    assign fwd_valid = 1'b0;
    assign fwd_rd    = '0;
    assign fwd_data  = '0;
`endif

endmodule

// File: tb/tb_ex_mem_skid.sv
// Scoreboard bench for ex_mem_skid; forwarding expectations follow EX_MEM_FWD_EN.
module tb_ex_mem_skid;
    import ex_mem_pkg::*;

`ifdef EX_MEM_FWD_EN
    localparam bit FWD_EN = 1'b1;
`else
    localparam bit FWD_EN = 1'b0;
`endif

    typedef logic [80:0] pay_t;

    logic        sys_clk, sys_rst, flush;
    logic        ex_valid, ex_ready;
    logic        ex_is_write_dmem, ex_reg_write;
    logic [4:0]  ex_rd;
    logic [1:0]  ex_wb_select;
    logic [7:0]  ex_write_width;
    logic [31:0] ex_dmem_write_data, ex_alu_res;
    logic        mem_valid, mem_ready;
    logic        mem_is_write_dmem, mem_reg_write;
    logic [4:0]  mem_rd;
    logic [1:0]  mem_wb_select;
    logic [7:0]  mem_write_width;
    logic [31:0] mem_dmem_write_data, mem_alu_res;
    logic        fwd_valid;
    logic [4:0]  fwd_rd;
    logic [31:0] fwd_data;

    int   n_vec  = 0;
    int   n_fail = 0;
    pay_t sb_q[$];

    ex_mem_skid dut (
        .sys_clk             (sys_clk),
        .sys_rst             (sys_rst),
        .flush               (flush),
        .ex_valid            (ex_valid),
        .ex_ready            (ex_ready),
        .ex_is_write_dmem    (ex_is_write_dmem),
        .ex_reg_write        (ex_reg_write),
        .ex_rd               (ex_rd),
        .ex_wb_select        (ex_wb_select),
        .ex_write_width      (ex_write_width),
        .ex_dmem_write_data  (ex_dmem_write_data),
        .ex_alu_res          (ex_alu_res),
        .mem_valid           (mem_valid),
        .mem_ready           (mem_ready),
        .mem_is_write_dmem   (mem_is_write_dmem),
        .mem_reg_write       (mem_reg_write),
        .mem_rd              (mem_rd),
        .mem_wb_select       (mem_wb_select),
        .mem_write_width     (mem_write_width),
        .mem_dmem_write_data (mem_dmem_write_data),
        .mem_alu_res         (mem_alu_res),
        .fwd_valid           (fwd_valid),
        .fwd_rd              (fwd_rd),
        .fwd_data            (fwd_data)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running, want finished");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic pay_t pack_ex();
        return {ex_is_write_dmem, ex_reg_write, ex_rd, ex_wb_select,
                ex_write_width, ex_dmem_write_data, ex_alu_res};
    endfunction

    function automatic pay_t pack_mem();
        return {mem_is_write_dmem, mem_reg_write, mem_rd, mem_wb_select,
                mem_write_width, mem_dmem_write_data, mem_alu_res};
    endfunction

    task automatic drive(input logic v, input logic wr, input logic rw, input logic [4:0] rd,
                         input logic [1:0] wb, input logic [7:0] ww,
                         input logic [31:0] wd, input logic [31:0] alu);
        ex_valid           = v;
        ex_is_write_dmem   = wr;
        ex_reg_write       = rw;
        ex_rd              = rd;
        ex_wb_select       = wb;
        ex_write_width     = ww;
        ex_dmem_write_data = wd;
        ex_alu_res         = alu;
    endtask

    task automatic offer(input logic [31:0] alu);
        drive(1'b1, alu[0], alu[1], alu[6:2], alu[8:7], alu[7:0] ^ 8'hA5, ~alu, alu);
    endtask

    // One clock: model checks and scoreboard update at negedge, then return at posedge+1.
    task automatic step();
        pay_t h;
        @(negedge sys_clk);
        if (sys_rst) begin
            sb_q.delete();
        end else begin
            check("occ_mem_valid", mem_valid, sb_q.size() != 0);
            check("occ_ex_ready", ex_ready, sb_q.size() < 2);
            if (!mem_valid) begin
                check("qual_write_dmem", mem_is_write_dmem, 1'b0);
                check("qual_reg_write", mem_reg_write, 1'b0);
            end
            if (FWD_EN && sb_q.size() != 0) begin
                h = sb_q[0];
                check("mon_fwd_valid", fwd_valid,
                      h[79] && (h[78:74] != 5'd0) && (h[73:72] != WB_MEM));
                check("mon_fwd_rd", fwd_rd, h[78:74]);
                check("mon_fwd_data", fwd_data, h[31:0]);
            end else if (!FWD_EN) begin
                check("mon_fwd_off", {fwd_valid, fwd_rd, fwd_data}, '0);
            end
            if (flush) begin
                sb_q.delete();
            end else begin
                if (mem_valid && mem_ready) begin
                    if (sb_q.size() == 0) check("sb_underflow", 1'b1, 1'b0);
                    else begin
                        h = sb_q.pop_front();
                        check("sb_payload", pack_mem(), h);
                    end
                end
                if (ex_valid && ex_ready) sb_q.push_back(pack_ex());
            end
        end
        @(posedge sys_clk);
        #1;
    endtask

    task automatic fwd_case(input logic [4:0] rd, input logic [1:0] wb, input logic exp_v);
        mem_ready = 1'b0;
        drive(1'b1, 1'b0, 1'b1, rd, wb, 8'h00, 32'h0, 32'hDEAD);
        step();
        ex_valid = 1'b0;
        check("fwd_valid", fwd_valid, FWD_EN ? exp_v : 1'b0);
        check("fwd_rd", fwd_rd, FWD_EN ? rd : 5'd0);
        check("fwd_data", fwd_data, FWD_EN ? 32'hDEAD : 32'h0);
        mem_ready = 1'b1;
        step();
    endtask

    initial begin
        int          acc;
        logic        hold;
        logic [31:0] v;

        sys_rst   = 1'b1;
        flush     = 1'b0;
        mem_ready = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 5'd0, 2'd0, 8'd0, 32'd0, 32'd0);
        #2;
        check("rst_mem_valid", mem_valid, 1'b0);
        check("rst_ex_ready", ex_ready, 1'b1);
        check("rst_fwd_valid", fwd_valid, 1'b0);
        check("rst_payload", pack_mem(), '0);
        @(negedge sys_clk);
        sys_rst = 1'b0;
        @(posedge sys_clk);
        #1;

        // Streaming: one result per cycle with no bubbles.
        for (int i = 1; i <= 8; i++) begin
            offer(i);
            step();
            check("stream_valid", mem_valid, 1'b1);
            check("stream_alu", mem_alu_res, i);
        end
        ex_valid = 1'b0;
        step();
        check("stream_empty", mem_valid, 1'b0);

        // Back-pressure: only two entries fit while MEM stalls.
        mem_ready = 1'b0;
        acc = 0;
        v = 32'h11;
        for (int c = 0; c < 3; c++) begin
            offer(v);
            hold = ex_ready;
            if (c == 2) check("bp_ready_low", ex_ready, 1'b0);
            step();
            if (hold) begin
                acc++;
                v++;
            end
        end
        check("bp_accepts", acc, 2);
        ex_valid  = 1'b0;
        mem_ready = 1'b1;
        step();
        check("bp_first_out", mem_alu_res, 32'h12);
        check("bp_ready_recover", ex_ready, 1'b1);
        for (int c = 0; c < 6 && sb_q.size() != 0; c++) step();
        check("bp_drained", mem_valid, 1'b0);

        // Flush kills a held store and the entry offered alongside it.
        mem_ready = 1'b0;
        drive(1'b1, 1'b1, 1'b0, 5'd3, WB_ALU, 8'h0F, 32'hCAFE, 32'h100);
        step();
        check("fl_store_wr", mem_is_write_dmem, 1'b1);
        check("fl_store_alu", mem_alu_res, 32'h100);
        offer(32'h200);
        step();
        check("fl_skid_full", ex_ready, 1'b0);
        flush = 1'b1;
        offer(32'h300);
        step();
        flush    = 1'b0;
        ex_valid = 1'b0;
        check("fl_mem_valid", mem_valid, 1'b0);
        check("fl_store_killed", mem_is_write_dmem, 1'b0);
        check("fl_ex_ready", ex_ready, 1'b1);
        mem_ready = 1'b1;
        step();
        check("fl_lost", mem_valid, 1'b0);
        offer(32'h400);
        flush = 1'b1;
        step();
        flush    = 1'b0;
        ex_valid = 1'b0;
        check("fl_accept_lost", mem_valid, 1'b0);

        // Simultaneous drain and accept: M reloads with no bubble.
        offer(32'h50);
        step();
        offer(32'h55);
        step();
        ex_valid = 1'b0;
        check("sim_valid", mem_valid, 1'b1);
        check("sim_alu", mem_alu_res, 32'h55);
        check("sim_ready", ex_ready, 1'b1);
        step();

        fwd_case(5'd7, WB_ALU, 1'b1);
        fwd_case(5'd0, WB_ALU, 1'b0);
        fwd_case(5'd7, WB_MEM, 1'b0);
        fwd_case(5'd9, WB_PC4, 1'b1);

        // Reset between edges with both slots full.
        mem_ready = 1'b0;
        offer(32'h77);
        step();
        offer(32'h78);
        step();
        ex_valid = 1'b0;
        check("mr_full", ex_ready, 1'b0);
        #2;
        sys_rst = 1'b1;
        #1;
        check("mr_mem_valid", mem_valid, 1'b0);
        check("mr_payload", pack_mem(), '0);
        check("mr_fwd", {fwd_valid, fwd_rd, fwd_data}, '0);
        @(negedge sys_clk);
        sys_rst = 1'b0;
        sb_q.delete();
        @(posedge sys_clk);
        #1;
        check("mr_ex_ready", ex_ready, 1'b1);
        check("mr_stay_empty", mem_valid, 1'b0);
        mem_ready = 1'b1;
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
